// File: rtl/tribuf_pkg.sv
// Shared definitions for the triple-buffer write controller and read mux:
// phase encodings, per-bank modes, and the phase-to-mode mapping.
package tribuf_pkg;

  typedef enum logic [1:0] {
    PHASE_0       = 2'd0,
    PHASE_1       = 2'd1,
    PHASE_2       = 2'd2,
    PHASE_INVALID = 2'd3
  } phase_t;

  typedef enum logic [1:0] {
    MODE_INPUT_STREAM = 2'd0,
    MODE_RUN_FFT      = 2'd1,
    MODE_DMA          = 2'd2,
    MODE_DISABLE      = 2'd3
  } bank_mode_t;

  localparam int NUM_BANKS = 3;

  // Each phase hands the three roles (input fill, FFT working set, DMA readout)
  // to a different bank; an invalid phase disables every bank.
  function automatic bank_mode_t phase_to_mode(input phase_t phase, input logic [1:0] bankIdx);
    bank_mode_t mode;
    mode = MODE_DISABLE;
    case (phase)
      PHASE_0: begin
        case (bankIdx)
          2'd0:    mode = MODE_INPUT_STREAM;
          2'd1:    mode = MODE_RUN_FFT;
          2'd2:    mode = MODE_DMA;
          default: mode = MODE_DISABLE;
        endcase
      end
      PHASE_1: begin
        case (bankIdx)
          2'd0:    mode = MODE_RUN_FFT;
          2'd1:    mode = MODE_DMA;
          2'd2:    mode = MODE_INPUT_STREAM;
          default: mode = MODE_DISABLE;
        endcase
      end
      PHASE_2: begin
        case (bankIdx)
          2'd0:    mode = MODE_DMA;
          2'd1:    mode = MODE_INPUT_STREAM;
          2'd2:    mode = MODE_RUN_FFT;
          default: mode = MODE_DISABLE;
        endcase
      end
      default: mode = MODE_DISABLE;
    endcase
    return mode;
  endfunction

  // Phase rotation order 0 -> 1 -> 2 -> 0; an invalid phase recovers to 0.
  function automatic phase_t next_phase(input phase_t phase);
    phase_t nxt;
    case (phase)
      PHASE_0: nxt = PHASE_1;
      PHASE_1: nxt = PHASE_2;
      default: nxt = PHASE_0;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/tribuf_write_ctrl_if.sv
// Bundle of the stream, FFT, DMA and bank-write signals around the
// triple-buffer write controller. The controller uses the slave view;
// the surrounding environment uses the master view.
interface tribuf_write_ctrl_if #(
  parameter int FFT_N  = 10,
  parameter int FFT_DW = 16
) ();

  localparam int AW = FFT_N - 1;
  localparam int DW = 2 * FFT_DW;

  logic          enable;
  logic          din_valid;
  logic [DW-1:0] din;
  logic          din_ready;

  logic          fft_start;
  logic          fft_done;
  logic          wact_fft;
  logic [AW-1:0] wa_fft;
  logic [DW-1:0] wdw_fft;

  logic          dma_start;
  logic          dma_done;

  logic [1:0]    tribuf_status;

  logic          wact_ram_bank0;
  logic          wact_ram_bank1;
  logic          wact_ram_bank2;
  logic [AW-1:0] wa_ram_bank0;
  logic [AW-1:0] wa_ram_bank1;
  logic [AW-1:0] wa_ram_bank2;
  logic [DW-1:0] wdw_ram_bank0;
  logic [DW-1:0] wdw_ram_bank1;
  logic [DW-1:0] wdw_ram_bank2;

  modport master (
    output enable, din_valid, din, fft_done, wact_fft, wa_fft, wdw_fft, dma_done,
    input  din_ready, fft_start, dma_start, tribuf_status,
    input  wact_ram_bank0, wact_ram_bank1, wact_ram_bank2,
    input  wa_ram_bank0, wa_ram_bank1, wa_ram_bank2,
    input  wdw_ram_bank0, wdw_ram_bank1, wdw_ram_bank2
  );

  modport slave (
    input  enable, din_valid, din, fft_done, wact_fft, wa_fft, wdw_fft, dma_done,
    output din_ready, fft_start, dma_start, tribuf_status,
    output wact_ram_bank0, wact_ram_bank1, wact_ram_bank2,
    output wa_ram_bank0, wa_ram_bank1, wa_ram_bank2,
    output wdw_ram_bank0, wdw_ram_bank1, wdw_ram_bank2
  );

endinterface

// File: rtl/tribuf_write_ctrl_wbmux.sv
// Per-bank write port: picks the stream or the FFT write-back as the source
// according to the bank's current mode and registers the result.
module writeBusMux
  import tribuf_pkg::*;
#(
  parameter int AW = 9,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  bank_mode_t    i_mode,
  input  logic          i_inWact,
  input  logic [AW-1:0] i_inAddr,
  input  logic [DW-1:0] i_inData,
  input  logic          i_fftWact,
  input  logic [AW-1:0] i_fftAddr,
  input  logic [DW-1:0] i_fftData,
  output logic          o_wact,
  output logic [AW-1:0] o_addr,
  output logic [DW-1:0] o_data
);

  logic          r_wact;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_data;

  // Register the selected source; address/data only move on a real write so an idle bank keeps its last values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wact <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
    end else begin
      case (i_mode)
        MODE_INPUT_STREAM: begin
          r_wact <= i_inWact;
          if (i_inWact) begin
            r_addr <= i_inAddr;
            r_data <= i_inData;
          end
        end
        MODE_RUN_FFT: begin
          r_wact <= i_fftWact;
          if (i_fftWact) begin
            r_addr <= i_fftAddr;
            r_data <= i_fftData;
          end
        end
        default: r_wact <= 1'b0;
      endcase
    end
  end

  assign o_wact = r_wact;
  assign o_addr = r_addr;
  assign o_data = r_data;

endmodule

// File: rtl/tribuf_write_ctrl.sv
// Triple-buffer write controller: fills the input bank from the sample
// stream, routes FFT write-backs, rotates the bank phase when a frame is
// full and both engines are idle, and kicks off the FFT and DMA engines.
module tribuf_write_ctrl
  import tribuf_pkg::*;
#(
  parameter int FFT_N  = 10,
  parameter int FFT_DW = 16
) (
  input logic                clk,
  input logic                rst_n,
  tribuf_write_ctrl_if.slave bus
);

  localparam int AW = FFT_N - 1;
  localparam int DW = 2 * FFT_DW;
  localparam logic [AW-1:0] FILL_LAST = '1;

  phase_t        r_status;
  logic [AW-1:0] r_fillCnt;
  logic          r_fillFull;
  logic          r_fftBusy;
  logic          r_fftHasResult;
  logic          r_dmaBusy;
  logic          r_fftStart;
  logic          r_dmaStart;

  logic          w_dinReady;
  logic          w_accept;
  logic          w_rotate;

  logic [NUM_BANKS-1:0] w_bankWact;
  logic [AW-1:0]        w_bankAddr [NUM_BANKS];
  logic [DW-1:0]        w_bankData [NUM_BANKS];

  assign w_dinReady = bus.enable && !r_fillFull;
  assign w_accept   = bus.din_valid && w_dinReady;

  // A done pulse in the same cycle holds off rotation until its busy flag has actually cleared.
  assign w_rotate = bus.enable && r_fillFull && !r_fftBusy && !r_dmaBusy
                    && !bus.fft_done && !bus.dma_done;

  // Frame fill counter: one slot per accepted sample, wrapping and flagging full on the last slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fillCnt  <= '0;
      r_fillFull <= 1'b0;
    end else if (w_rotate) begin
      r_fillFull <= 1'b0;
    end else if (w_accept) begin
      if (r_fillCnt == FILL_LAST) begin
        r_fillCnt  <= '0;
        r_fillFull <= 1'b1;
      end else begin
        r_fillCnt <= r_fillCnt + AW'(1);
      end
    end
  end

  // Phase rotation and engine tracking; start pulses are registered and last one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_status       <= PHASE_0;
      r_fftBusy      <= 1'b0;
      r_fftHasResult <= 1'b0;
      r_dmaBusy      <= 1'b0;
      r_fftStart     <= 1'b0;
      r_dmaStart     <= 1'b0;
    end else begin
      r_fftStart <= 1'b0;
      r_dmaStart <= 1'b0;
      if (w_rotate) begin
        r_status       <= next_phase(r_status);
        r_fftStart     <= 1'b1;
        r_fftBusy      <= 1'b1;
        r_fftHasResult <= 1'b0;
        if (r_fftHasResult) begin
          r_dmaStart <= 1'b1;
          r_dmaBusy  <= 1'b1;
        end
      end else begin
        if (bus.fft_done && r_fftBusy) begin
          r_fftBusy      <= 1'b0;
          r_fftHasResult <= 1'b1;
        end
        if (bus.dma_done && r_dmaBusy) begin
          r_dmaBusy <= 1'b0;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_BANKS; g++) begin : gBank
    bank_mode_t w_mode;
    assign w_mode = phase_to_mode(r_status, 2'(g));

    writeBusMux #(
      .AW(AW),
      .DW(DW)
    ) uWriteBusMux (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_mode    (w_mode),
      .i_inWact  (w_accept),
      .i_inAddr  (r_fillCnt),
      .i_inData  (bus.din),
      .i_fftWact (bus.wact_fft),
      .i_fftAddr (bus.wa_fft),
      .i_fftData (bus.wdw_fft),
      .o_wact    (w_bankWact[g]),
      .o_addr    (w_bankAddr[g]),
      .o_data    (w_bankData[g])
    );
  end

  assign bus.din_ready     = w_dinReady;
  assign bus.fft_start     = r_fftStart;
  assign bus.dma_start     = r_dmaStart;
  assign bus.tribuf_status = r_status;

  assign bus.wact_ram_bank0 = w_bankWact[0];
  assign bus.wact_ram_bank1 = w_bankWact[1];
  assign bus.wact_ram_bank2 = w_bankWact[2];
  assign bus.wa_ram_bank0   = w_bankAddr[0];
  assign bus.wa_ram_bank1   = w_bankAddr[1];
  assign bus.wa_ram_bank2   = w_bankAddr[2];
  assign bus.wdw_ram_bank0  = w_bankData[0];
  assign bus.wdw_ram_bank1  = w_bankData[1];
  assign bus.wdw_ram_bank2  = w_bankData[2];

endmodule

// File: doc/tribuf_write_ctrl.md
Name: tribuf_write_ctrl

Overview:
- Write-side companion to the triple-buffer read-bus mux, and the owner of `tribuf_status`.
- Accepts the input sample stream and writes it sequentially into the bank in INPUT_STREAM mode.
- Routes FFT-unit write-backs into the bank in RUN_FFT mode.
- Rotates the phase PHASE_0 -> PHASE_1 -> PHASE_2 -> PHASE_0 when a frame is full and both the FFT and DMA units are idle.
- Issues start pulses to the FFT and DMA engines.
- Sits between the stream source, the FFT core, the DMA engine and the three RAM banks.

Parameters:
- FFT_N, 10, log2 FFT length; bank word address width is FFT_N-1.
- FFT_DW, 16, width of each real/imag component; bank word width is 2*FFT_DW.
- PHASE_0/PHASE_1/PHASE_2, 0/1/2, `tribuf_status` encodings.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  allows stream acceptance and phase rotation
- din_valid  in  1  input sample valid
- din  in  2*FFT_DW  input sample {re,im}
- din_ready  out  1  sample accepted when din_valid && din_ready
- fft_start  out  1  one-cycle pulse: FFT bank loaded, begin transform
- fft_done  in  1  one-cycle pulse from FFT core: transform complete
- wact_fft  in  1  FFT write strobe
- wa_fft  in  FFT_N-1  FFT write address
- wdw_fft  in  2*FFT_DW  FFT write data
- dma_start  out  1  one-cycle pulse: result bank ready for readout
- dma_done  in  1  one-cycle pulse from DMA: readout complete
- tribuf_status  out  2  current phase, drives the read mux
- wact_ram_bank0/1/2  out  1  bank write strobe
- wa_ram_bank0/1/2  out  FFT_N-1  bank write address
- wdw_ram_bank0/1/2  out  2*FFT_DW  bank write data

Behaviour:
- Bank mode per phase:
  - PHASE_0: bank0 = INPUT, bank1 = FFT, bank2 = DMA.
  - PHASE_1: bank0 = FFT, bank1 = DMA, bank2 = INPUT.
  - PHASE_2: bank0 = DMA, bank1 = INPUT, bank2 = FFT.
  - Value 3 is never generated; if present, all bank write strobes are forced to 0.
- Reset values:
  - tribuf_status = PHASE_0; fill_cnt = 0; fill_full = 0.
  - fft_busy = 0; fft_has_result = 0; dma_busy = 0.
  - All wact_ram_* = 0, wa_ram_* = 0, wdw_ram_* = 0.
  - fft_start = 0, dma_start = 0.
  - din_ready is combinational = enable && !fill_full, so it may be 1 during reset.
- Stream fill:
  - Each accepted sample at cycle T produces, at T+1, a write to the INPUT bank: wact = 1, wa = fill_cnt, wdw = din.
  - fill_cnt then increments.
  - On the accept with fill_cnt = 2^(FFT_N-1)-1: fill_full <= 1 and fill_cnt wraps to 0.
- FFT write path:
  - wact_fft/wa_fft/wdw_fft are registered into the FFT bank with 1-cycle latency.
  - Writes are accepted regardless of fft_busy.
- Bank selection and isolation:
  - Bank selection uses the phase in effect at acceptance time.
  - Unselected banks have wact = 0; their address and data hold their last values.
- FFT tracking:
  - fft_start sets fft_busy.
  - fft_done clears fft_busy and sets fft_has_result.
- DMA tracking:
  - dma_start sets dma_busy; dma_done clears it.
  - A done pulse while not busy is ignored.
- Rotation condition, evaluated on registered state at cycle T: enable && fill_full && !fft_busy && !dma_busy.
- When rotating, at T+1:
  - tribuf_status advances by one, with 2 -> 0.
  - fill_full = 0.
  - fft_start = 1 and fft_busy = 1.
  - dma_start = 1 and dma_busy = 1 only if fft_has_result was 1 at T.
  - fft_has_result = 0.
- Simultaneous events:
  - A done pulse arriving in the same cycle as an otherwise-true rotation condition delays rotation by one cycle.
  - A sample offered while fill_full is held off via din_ready = 0; no data is lost.
- enable low:
  - No acceptance and no rotation.
  - In-flight FFT/DMA and their done handling continue.
  - fill_cnt is held.
- Reset mid-operation: asynchronous clear of all state to the reset values; any partial frame is discarded.

Decomposition:
- Shared package tribuf_pkg:
  - Phase constants PHASE_0..2.
  - Mode constants MODE_INPUT_STREAM/RUN_FFT/DMA/DISABLE.
  - Function phase_to_mode(phase, bank_idx) returning the bank mode.
  - The read mux also uses this package.
- Sub-module writeBusMux: one instance per bank, selects the INPUT or FFT write source by mode, with the output register included.

Test Plan (FFT_N = 4, bank depth 8):
1. Reset, stream 8 samples 0x00010001..0x00080008 back-to-back -> bank0 writes addresses 0..7 at cycles T+1..T+8; then rotation, tribuf_status = 1, fft_start pulse, dma_start stays 0.
2. Second frame fills bank2 while fft_busy; din_ready drops after the 8th sample; fft_done pulse -> next cycle rotation to PHASE_2, fft_start = 1 and dma_start = 1 together, dma_busy set.
3. FFT write wa_fft = 5, wdw_fft = 0xABCD1234 in PHASE_1 -> wact_ram_bank0 = 1, wa = 5, data matches next cycle; bank1/bank2 strobes stay 0.
4. Frame full and fft_done in the same cycle -> rotation occurs exactly one cycle later; with dma_busy held high, no rotation until dma_done.
5. Deassert enable mid-frame at sample 3 -> din_ready = 0 and fill_cnt holds at 3; re-enable -> next write lands at address 3.
6. Assert rst_n low mid-frame in PHASE_2 -> all outputs take reset values immediately; after release the next frame writes bank0 starting at address 0.
